// File: rtl/snap_reg_master_if.sv
// Command/response and snapshot-register partition bus for snap_reg_master.
// The master modport is the initiator's view; the slave modport is the command source and register side.
interface snap_reg_master_if #(
  parameter int W_WIDTH    = 32,
  parameter int F_WIDTH    = 36,
  parameter int ADDR_WIDTH = 7
);
  localparam int PARTITION_CNT = (F_WIDTH + W_WIDTH - 1) / W_WIDTH;

  logic                     cmd_vld;
  logic                     cmd_rdy;
  logic                     cmd_wr;
  logic [ADDR_WIDTH-1:0]    cmd_addr;
  logic [F_WIDTH-1:0]       cmd_wr_data;
  logic                     rsp_vld;
  logic                     rsp_err;
  logic [F_WIDTH-1:0]       rsp_rd_data;
  logic [ADDR_WIDTH-1:0]    sw_addr;
  logic [PARTITION_CNT-1:0] sw_rd;
  logic [PARTITION_CNT-1:0] sw_wr;
  logic [W_WIDTH-1:0]       sw_wr_data;
  logic                     req_vld;
  logic [W_WIDTH-1:0]       sw_rd_data;
  logic                     ack_vld;

  modport master (
    input  cmd_vld, cmd_wr, cmd_addr, cmd_wr_data, sw_rd_data, ack_vld,
    output cmd_rdy, rsp_vld, rsp_err, rsp_rd_data,
           sw_addr, sw_rd, sw_wr, sw_wr_data, req_vld
  );

  modport slave (
    output cmd_vld, cmd_wr, cmd_addr, cmd_wr_data, sw_rd_data, ack_vld,
    input  cmd_rdy, rsp_vld, rsp_err, rsp_rd_data,
           sw_addr, sw_rd, sw_wr, sw_wr_data, req_vld
  );
endinterface

// File: rtl/snap_reg_master.sv
// Splits one F_WIDTH command into W_WIDTH snapshot-register accesses; read latency 1+PARTITION_CNT*(k+1), write 1+PARTITION_CNT+WR_GAP.
// One command in flight: cmd_rdy is high only in IDLE, and a read waits at most TIMEOUT cycles per partition ack.
module snap_reg_master #(
  parameter int W_WIDTH    = 32,
  parameter int F_WIDTH    = 36,
  parameter int ADDR_WIDTH = 7,
  parameter int TIMEOUT    = 16,
  parameter int WR_GAP     = 3
) (
  input logic                clk,
  input logic                rst_n,
  snap_reg_master_if.master  bus
);
  localparam int PARTITION_CNT = (F_WIDTH + W_WIDTH - 1) / W_WIDTH;
  localparam int PW            = PARTITION_CNT * W_WIDTH;
  localparam int REM           = (F_WIDTH % W_WIDTH == 0) ? W_WIDTH : F_WIDTH % W_WIDTH;
  localparam int IDX_W         = (PARTITION_CNT > 1) ? $clog2(PARTITION_CNT) : 1;
  localparam int CNT_W         = $clog2(TIMEOUT + 1);
  localparam int GAP_W         = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

  localparam logic [IDX_W-1:0]   LAST      = IDX_W'(PARTITION_CNT - 1);
  localparam logic [W_WIDTH-1:0] TOP_MASK  = W_WIDTH'({REM{1'b1}});
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    RD_REQ    = 6'b000010,
    RD_WAIT   = 6'b000100,
    WR_PART   = 6'b001000,
    WR_GAP_ST = 6'b010000,
    RSP       = 6'b100000
  } state_t;

  state_t                state_ff, state_nxt;
  logic [IDX_W-1:0]      idx_ff, idx_nxt;
  logic [CNT_W-1:0]      cnt_ff, cnt_nxt, cnt_inc;
  logic [GAP_W-1:0]      gap_ff, gap_nxt;
  logic [ADDR_WIDTH-1:0] addr_ff, addr_nxt;
  logic                  wr_ff, wr_nxt;
  logic                  err_ff, err_nxt;
  logic [F_WIDTH-1:0]    wr_data_ff, wr_data_nxt;
  logic [F_WIDTH-1:0]    rd_buf_ff;
  logic [PW-1:0]         rd_buf_nxt;
  logic [PW-1:0]         wr_pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_ff   <= IDLE;
      idx_ff     <= '0;
      cnt_ff     <= '0;
      gap_ff     <= '0;
      addr_ff    <= '0;
      wr_ff      <= 1'b0;
      err_ff     <= 1'b0;
      wr_data_ff <= '0;
      rd_buf_ff  <= '0;
    end else begin
      state_ff   <= state_nxt;
      idx_ff     <= idx_nxt;
      cnt_ff     <= cnt_nxt;
      gap_ff     <= gap_nxt;
      addr_ff    <= addr_nxt;
      wr_ff      <= wr_nxt;
      err_ff     <= err_nxt;
      wr_data_ff <= wr_data_nxt;
      rd_buf_ff  <= F_WIDTH'(rd_buf_nxt);
    end
  end

  // Saturating so a stuck counter can never wrap back below TIMEOUT.
  assign cnt_inc = (cnt_ff == TIMEOUT_C) ? cnt_ff : cnt_ff + CNT_W'(1);

  always_comb begin
    state_nxt   = state_ff;
    idx_nxt     = idx_ff;
    cnt_nxt     = cnt_ff;
    gap_nxt     = gap_ff;
    addr_nxt    = addr_ff;
    wr_nxt      = wr_ff;
    err_nxt     = err_ff;
    wr_data_nxt = wr_data_ff;
    rd_buf_nxt  = PW'(rd_buf_ff);
    case (state_ff)
      IDLE: begin
        if (bus.cmd_vld) begin
          addr_nxt    = bus.cmd_addr;
          wr_nxt      = bus.cmd_wr;
          wr_data_nxt = bus.cmd_wr_data;
          rd_buf_nxt  = '0;
          cnt_nxt     = '0;
          gap_nxt     = '0;
          err_nxt     = 1'b0;
          idx_nxt     = bus.cmd_wr ? LAST : '0;
          state_nxt   = bus.cmd_wr ? WR_PART : RD_REQ;
        end
      end
      RD_REQ: begin
        cnt_nxt   = '0;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.ack_vld) begin
          // Top partition only carries REM meaningful bits.
          rd_buf_nxt[idx_ff*W_WIDTH +: W_WIDTH] =
            bus.sw_rd_data & ((idx_ff == LAST) ? TOP_MASK : '1);
          if (idx_ff == LAST) begin
            state_nxt = RSP;
          end else begin
            idx_nxt   = idx_ff + IDX_W'(1);
            state_nxt = RD_REQ;
          end
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            err_nxt   = 1'b1;
            state_nxt = RSP;
          end
        end
      end
      WR_PART: begin
        if (idx_ff == '0) begin
          gap_nxt   = '0;
          state_nxt = (WR_GAP == 0) ? RSP : WR_GAP_ST;
        end else begin
          idx_nxt = idx_ff - IDX_W'(1);
        end
      end
      WR_GAP_ST: begin
        if (gap_ff == GAP_LAST) state_nxt = RSP;
        else                    gap_nxt   = gap_ff + GAP_W'(1);
      end
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_pad = PW'(wr_data_ff);

  assign bus.cmd_rdy     = (state_ff == IDLE);
  assign bus.rsp_vld     = (state_ff == RSP);
  assign bus.rsp_err     = (state_ff == RSP) && err_ff;
  assign bus.rsp_rd_data = ((state_ff == RSP) && !wr_ff) ? rd_buf_ff : '0;
  assign bus.req_vld     = (state_ff == RD_REQ);
  assign bus.sw_addr     = ((state_ff == RD_REQ) || (state_ff == RD_WAIT) || (state_ff == WR_PART))
                           ? addr_ff : '0;
  assign bus.sw_rd       = (state_ff == RD_REQ)  ? (PARTITION_CNT'(1) << idx_ff) : '0;
  assign bus.sw_wr       = (state_ff == WR_PART) ? (PARTITION_CNT'(1) << idx_ff) : '0;
  assign bus.sw_wr_data  = (state_ff == WR_PART) ? wr_pad[idx_ff*W_WIDTH +: W_WIDTH] : '0;
endmodule

// File: doc/snap_reg_master.md
# snap_reg_master

Initiator for the snapshot-register software interface. It accepts a full-width (F_WIDTH) read or write command and splits it into W_WIDTH partition accesses on the `sw_*`/`req_vld`/`ack_vld` port of a snapshot register, then returns one response. Reads access partition 0 first, because that access triggers the memory snapshot, then the upper partitions. Writes go top partition first and partition 0 last, because the partition-0 write commits the entry to memory.

## Interface

- W_WIDTH, 32, bus/partition width
- F_WIDTH, 36, full entry width
- PARTITION_CNT, ceil(F_WIDTH/W_WIDTH), derived, not overridden
- ADDR_WIDTH, 7, entry address width
- TIMEOUT, 16, maximum cycles spent waiting for each read ack; must be ≥1
- WR_GAP, 3, idle cycles inserted after the partition-0 write strobe
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_vld  input  1  command request
- cmd_rdy  output  1  ready to accept a command; high only in IDLE
- cmd_wr  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  entry address
- cmd_wr_data  input  F_WIDTH  write data
- rsp_vld  output  1  one-cycle response pulse
- rsp_err  output  1  read ack timeout; valid with rsp_vld
- rsp_rd_data  output  F_WIDTH  assembled read data; valid with rsp_vld
- sw_addr  output  ADDR_WIDTH  partition access address
- sw_rd  output  PARTITION_CNT  one-hot read select
- sw_wr  output  PARTITION_CNT  one-hot write strobe
- sw_wr_data  output  W_WIDTH  partition write data
- req_vld  output  1  read request pulse
- sw_rd_data  input  W_WIDTH  partition read data; valid when ack_vld is high
- ack_vld  input  1  read partition acknowledge

## Operation

- **States:** IDLE, RD_REQ, RD_WAIT, WR_PART, WR_GAP, RSP (one-hot).
- **Command accept:** a command is accepted on a clock edge where cmd_vld && cmd_rdy.
  - cmd_addr, cmd_wr and cmd_wr_data are registered.
  - The read buffer and timeout counter clear.
  - The partition index idx is set to 0 for a read, or to PARTITION_CNT-1 for a write.
  - IDLE moves to RD_REQ (read) or WR_PART (write).
- **RD_REQ** (1 cycle): req_vld=1, sw_rd=onehot(idx), sw_addr=addr_ff. Next state is RD_WAIT.
- **RD_WAIT:** sw_rd and req_vld are 0.
  - On ack_vld, sw_rd_data is captured into buf[idx*W_WIDTH +: W_WIDTH]. For the top partition, only the low REM bits are kept; REM = F_WIDTH%W_WIDTH, or W_WIDTH if that is 0.
  - After the capture: if idx==PARTITION_CNT-1, go to RSP; otherwise idx++ and go to RD_REQ.
  - Otherwise the counter increments. When it reaches TIMEOUT, go to RSP with err=1.
  - The counter clears on each RD_REQ.
- **ack_vld outside RD_WAIT:** ignored, with no state or data effect.
- **WR_PART** (1 cycle per partition): sw_wr=onehot(idx), sw_addr=addr_ff, sw_wr_data=wr_data_ff slice for idx.
  - The top partition is zero-padded above REM.
  - req_vld stays 0.
  - If idx==0, go to WR_GAP; otherwise idx-- and stay in WR_PART.
- **WR_GAP:** all sw_* outputs are 0 for WR_GAP cycles, then go to RSP with err=0.
- **RSP** (1 cycle): rsp_vld=1.
  - rsp_rd_data=buf for reads and 0 for writes.
  - After a timeout, the partitions not captured read as 0.
  - Next state is IDLE.
- **Outputs outside the active phases:** sw_addr, sw_rd, sw_wr, sw_wr_data and req_vld are 0 outside RD_REQ/WR_PART, except that sw_addr=addr_ff in RD_WAIT.
- **Reset values:** cmd_rdy=1; every other output 0; state=IDLE; all buffers and counters 0.
- **Reset mid-command:** the command is aborted immediately. No rsp_vld is issued for it.

## Timing

- **Read:** accepted at edge T.
  - req_vld/sw_rd are high in cycle T+1.
  - For a target that acks k cycles after req (k≥1), each partition takes k+1 cycles.
  - rsp_vld occurs at T+1+PARTITION_CNT*(k+1). With the snapshot register (k=2), PARTITION_CNT=2 gives rsp_vld at T+7.
- **Timeout:** rsp_vld comes TIMEOUT+1 cycles after the offending req_vld cycle.
- **Write:** strobes are in cycles T+1 … T+PARTITION_CNT, then WR_GAP idle cycles. rsp_vld occurs at T+PARTITION_CNT+WR_GAP+1.
- **Next command:** cmd_rdy rises the cycle after rsp_vld, so the minimum command spacing is latency+1.
- **Timeout counter:** width is clog2(TIMEOUT+1) and it saturates; it never wraps.

## Test plan

- **Reset:** hold rst_n=0 with random inputs.
  - Required: cmd_rdy=1; rsp_vld, req_vld, sw_rd, sw_wr, sw_addr, sw_wr_data, rsp_rd_data all 0.
- **Read of addr 0x05:** responder acks 2 cycles after each req, with data 32'hDEADBEEF then 32'hFFFFFFFA.
  - Required: sw_rd sequence 2'b01 then 2'b10, sw_addr=0x05.
  - Required: rsp_vld 7 cycles after accept, with rsp_rd_data=36'hADEADBEEF and rsp_err=0.
- **Write of addr 0x12, data 36'h912345678:**
  - Required: cycle T+1 has sw_wr=2'b10 and sw_wr_data=32'h00000009.
  - Required: cycle T+2 has sw_wr=2'b01 and sw_wr_data=32'h12345678.
  - Required: sw_addr=0x12 in both cycles, req_vld=0 throughout, and rsp_vld at T+6 with rsp_rd_data=0.
- **Timeout:** partition 0 acks with 32'h11111111, partition 1 never acks.
  - Required: rsp_vld 17 cycles after the second req_vld, with rsp_err=1 and rsp_rd_data=36'h011111111.
- **Busy and stray acks:** hold cmd_vld=1 with changing cmd_addr during a read, and inject an ack_vld pulse during RD_REQ.
  - Required: the command is not re-accepted while cmd_rdy=0, and the stray ack is ignored.
  - Required: the next command is accepted the cycle after rsp_vld, using the cmd_addr presented then.
- **Reset mid-read:** assert rst_n=0 during RD_WAIT of partition 1.
  - Required: outputs return to reset values asynchronously, no rsp_vld is issued, and a fresh read afterwards completes normally.
